hack_cpu_mc: RTL and testbench
==============================

Name: hack_cpu_mc

Overview:
- Parametrised multi-cycle Hack CPU, successor to the current fixed-16-bit core.
- Sits between ROM (instruction port) and the RAM/MMIO bus (mem_* port).
- Adds over the current core:
  - generic data and PC width
  - a configurable slow-MMIO address window with a programmable settle count
  - an instruction-valid handshake
  - a halt request
  - an internal instruction register

Parameters:
- WIDTH, 16: data/instruction width; MSB is the A/C-instruction select.
- PC_WIDTH, 15: program counter width; PC wraps modulo 2^PC_WIDTH.
- SLOW_LO, 16'h4000: lowest address of the slow (MMIO) window, inclusive.
- SLOW_HI, 16'h5FFF: highest address of the slow window, inclusive.
- MMIO_WAIT, 2: extra wait cycles after mem_busy drops on a slow access; 0 is legal.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- instruction  in  WIDTH  ROM data for address prog_counter
- instr_valid  in  1  instruction is valid this cycle
- halt  in  1  request to stop before the next fetch
- mem_busy  in  1  slow device not ready
- mem_rdata  in  WIDTH  RAM/MMIO read data at mem_address
- mem_load  out  1  write strobe
- mem_address  out  WIDTH  always equals the A register
- mem_wdata  out  WIDTH  ALU result
- prog_counter  out  PC_WIDTH  fetch address
- halted  out  1  high while parked in FETCH due to halt

Behaviour:
- Reset values (asynchronous on reset_n low):
  - A, D, IR, MDR, prog_counter = 0
  - state = FETCH
  - mem_load = 0, halted = 0
  - wait counter = 0
- Reset mid-operation aborts at once; mem_load drops combinationally with reset.
- slow = (A >= SLOW_LO) && (A <= SLOW_HI); compared unsigned, evaluated on the current A.
- FETCH:
  - If halt: stay, halted = 1.
  - Else if instr_valid: IR <= instruction, MDR <= mem_rdata, halted = 0, go to DECODE.
  - Else: stay, halted = 0.
- DECODE, A-instruction (IR[WIDTH-1] = 0):
  - A <= IR; PC <= PC+1; go to SETTLE.
- DECODE, C-instruction:
  - Latch zx,nx,zy,ny,f,no = IR[11:6].
  - ALU x <= D.
  - ALU y <= IR[12] ? MDR : A.
  - Go to EXEC.
- ALU (Hack semantics, WIDTH bits):
  - zx/nx/zy/ny condition the inputs.
  - f selects add (wraps, no carry out) or bitwise AND.
  - no inverts the output.
  - zero = (out == 0); neg = out[WIDTH-1].
- EXEC:
  - mem_load = d3 (IR[3]) for every cycle in EXEC, including stall cycles.
  - Stall while d3 && slow && mem_busy.
  - Otherwise commit, all sampled on the old A in this cycle:
    - if d1 (IR[5]): A <= out
    - if d2 (IR[4]): D <= out
    - jump = (j1 && neg) || (j2 && zero) || (j3 && !neg && !zero)
    - PC <= jump ? A[PC_WIDTH-1:0] : PC+1
    - go to SETTLE
  - d1 together with d3 writes memory at the old A.
  - Jump bits 111 is an unconditional jump.
- SETTLE (uses the new A):
  - If !slow: go to FETCH.
  - Else if mem_busy: stay.
  - Else if MMIO_WAIT = 0: go to FETCH.
  - Else: counter <= MMIO_WAIT, go to WAIT.
- WAIT: decrement the counter; when counter == 1, go to FETCH. Total time in WAIT is exactly MMIO_WAIT cycles.
- Latency, fast path with instr_valid held high:
  - A-instruction: 3 cycles (FETCH, DECODE, SETTLE).
  - C-instruction: 4 cycles.
- PC wraps from 2^PC_WIDTH-1 to 0.
- halt is sampled only in FETCH; an in-flight instruction always completes.

Optional Feature:
- Macro: HACK_CPU_RETIRE_CNT_EN.
- When defined:
  - Extra output port retired [31:0], reset to 0.
  - Increments by 1 on each A-instruction DECODE and each C-instruction EXEC commit.
  - Wraps at 2^32.
  - Holds during stalls and halt.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- A-instruction to fast address:
  - Stimulus: after reset, instruction=16'h0010, instr_valid=1.
  - Response: mem_address=0x0010 and PC=1 three cycles after reset release; state back at FETCH.
- C-instruction D=A+1, then M=D with A=0x4000:
  - Stimulus: mem_busy high for 5 cycles.
  - Response: mem_load high for the whole EXEC stall; commit after busy falls; then 2 WAIT cycles before FETCH; mem_wdata=0x4001.
- Jump:
  - Stimulus: A=0x0007, D=0, D;JEQ.
  - Response: PC=7.
  - Stimulus: same with D=1.
  - Response: PC=old+1.
- Wrap:
  - Stimulus: PC=0x7FFF, A-instruction.
  - Response: PC=0; D=0xFFFF after D=-1.
- Halt and instr_valid:
  - Stimulus: halt asserted mid-C-instruction.
  - Response: instruction completes; halted=1 in FETCH.
  - Stimulus: halt released with instr_valid=0 for 3 cycles.
  - Response: stays in FETCH; no IR update.
- Async reset:
  - Stimulus: reset_n low during EXEC with d3=1.
  - Response: mem_load=0 immediately; all registers 0; retired=0 when HACK_CPU_RETIRE_CNT_EN is defined.

Source files
------------

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: FETCH/DECODE/EXEC/SETTLE/WAIT sequencer with a slow MMIO window.
// Optional retired-instruction counter behind `HACK_CPU_RETIRE_CNT_EN.
module hack_cpu_mc #(
    parameter int                WIDTH     = 16,
    parameter int                PC_WIDTH  = 15,
    parameter logic [WIDTH-1:0]  SLOW_LO   = 16'h4000,
    parameter logic [WIDTH-1:0]  SLOW_HI   = 16'h5FFF,
    parameter int unsigned       MMIO_WAIT = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [WIDTH-1:0]    instruction,
    input  logic                instr_valid,
    input  logic                halt,
    input  logic                mem_busy,
    input  logic [WIDTH-1:0]    mem_rdata,
    output logic                mem_load,
    output logic [WIDTH-1:0]    mem_address,
    output logic [WIDTH-1:0]    mem_wdata,
    output logic [PC_WIDTH-1:0] prog_counter,
`ifdef HACK_CPU_RETIRE_CNT_EN
    output logic                halted,
    output logic [31:0]         retired
`else
    output logic                halted
`endif
);

    localparam int CW = (MMIO_WAIT < 2) ? 1 : $clog2(MMIO_WAIT + 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_SETTLE,
        S_WAIT
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_d;
    logic [WIDTH-1:0]    r_ir;
    logic [WIDTH-1:0]    r_mdr;
    logic [WIDTH-1:0]    r_x;
    logic [WIDTH-1:0]    r_y;
    logic [5:0]          r_ctl;
    logic [PC_WIDTH-1:0] r_pc;
    logic [CW-1:0]       r_cnt;
    logic                r_halted;

    logic [WIDTH-1:0]    w_x0;
    logic [WIDTH-1:0]    w_x1;
    logic [WIDTH-1:0]    w_y0;
    logic [WIDTH-1:0]    w_y1;
    logic [WIDTH-1:0]    w_f;
    logic [WIDTH-1:0]    w_out;
    logic                w_zero;
    logic                w_neg;
    logic                w_slow;
    logic                w_stall;
    logic                w_jump;
    logic                w_is_c;
    logic                w_fetch_go;
    logic [PC_WIDTH-1:0] w_pc_inc;

    // ALU operands are latched at DECODE, so the result is stable for the whole EXEC stall.
    assign w_x0   = r_ctl[5] ? '0 : r_x;
    assign w_x1   = r_ctl[4] ? ~w_x0 : w_x0;
    assign w_y0   = r_ctl[3] ? '0 : r_y;
    assign w_y1   = r_ctl[2] ? ~w_y0 : w_y0;
    assign w_f    = r_ctl[1] ? (w_x1 + w_y1) : (w_x1 & w_y1);
    assign w_out  = r_ctl[0] ? ~w_f : w_f;
    assign w_zero = (w_out == '0);
    assign w_neg  = w_out[WIDTH-1];

    assign w_is_c     = r_ir[WIDTH-1];
    assign w_slow     = (r_a >= SLOW_LO) && (r_a <= SLOW_HI);
    assign w_stall    = r_ir[3] && w_slow && mem_busy;
    assign w_jump     = (r_ir[2] && w_neg) || (r_ir[1] && w_zero) ||
                        (r_ir[0] && !w_neg && !w_zero);
    assign w_fetch_go = !halt && instr_valid;
    assign w_pc_inc   = r_pc + PC_WIDTH'(1);

    assign mem_load     = reset_n && (r_state == S_EXEC) && r_ir[3];
    assign mem_address  = r_a;
    assign mem_wdata    = w_out;
    assign prog_counter = r_pc;
    assign halted       = r_halted;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_FETCH;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_FETCH:  if (w_fetch_go) w_state_nx = S_DECODE;
            S_DECODE: w_state_nx = w_is_c ? S_EXEC : S_SETTLE;
            S_EXEC:   if (!w_stall) w_state_nx = S_SETTLE;
            S_SETTLE: begin
                if (!w_slow)
                    w_state_nx = S_FETCH;
                else if (!mem_busy)
                    w_state_nx = (MMIO_WAIT == 0) ? S_FETCH : S_WAIT;
            end
            S_WAIT:   if (r_cnt == CW'(1)) w_state_nx = S_FETCH;
            default:  w_state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a      <= '0;
            r_d      <= '0;
            r_ir     <= '0;
            r_mdr    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_ctl    <= '0;
            r_pc     <= '0;
            r_cnt    <= '0;
            r_halted <= 1'b0;
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    r_halted <= halt;
                    if (w_fetch_go) begin
                        r_ir  <= instruction;
                        r_mdr <= mem_rdata;
                    end
                end
                S_DECODE: begin
                    if (!w_is_c) begin
                        r_a  <= r_ir;
                        r_pc <= w_pc_inc;
                    end else begin
                        r_ctl <= r_ir[11:6];
                        r_x   <= r_d;
                        r_y   <= r_ir[12] ? r_mdr : r_a;
                    end
                end
                S_EXEC: begin
                    // Jump target and memory address both use A as it was before this commit.
                    if (!w_stall) begin
                        if (r_ir[5]) r_a <= w_out;
                        if (r_ir[4]) r_d <= w_out;
                        r_pc <= w_jump ? r_a[PC_WIDTH-1:0] : w_pc_inc;
                    end
                end
                S_SETTLE: if (w_slow && !mem_busy) r_cnt <= CW'(MMIO_WAIT);
                S_WAIT:   r_cnt <= r_cnt - CW'(1);
                default:  ;
            endcase
        end
    end

`ifdef HACK_CPU_RETIRE_CNT_EN
    logic [31:0] r_retired;
    assign retired = r_retired;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_retired <= '0;
        else if (((r_state == S_DECODE) && !w_is_c) || ((r_state == S_EXEC) && !w_stall))
            r_retired <= r_retired + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Bench for hack_cpu_mc: directed program plus random instructions/handshakes,
// checked every cycle against an instruction-level timeline model.
module tb_hack_cpu_mc;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        halt;
    logic        mem_busy;
    logic [15:0] mem_rdata;
    logic        mem_load;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [14:0] prog_counter;
    logic        halted;
`ifdef HACK_CPU_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    hack_cpu_mc dut (
        .clk(clk), .reset_n(reset_n), .instruction(instruction),
        .instr_valid(instr_valid), .halt(halt), .mem_busy(mem_busy),
        .mem_rdata(mem_rdata), .mem_load(mem_load), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .prog_counter(prog_counter),
`ifdef HACK_CPU_RETIRE_CNT_EN
        .retired(retired),
`endif
        .halted(halted)
    );

    always #5 clk = ~clk;

    logic [15:0] rom  [32768];
    logic [15:0] ram  [65536];
    logic [15:0] mram [65536];

    assign instruction = rom[prog_counter];
    assign mem_rdata   = ram[mem_address];
    always @(posedge clk) if (mem_load) ram[mem_address] <= mem_wdata;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic slow(input logic [15:0] a);
        return (a >= 16'h4000) && (a <= 16'h5FFF);
    endfunction

    function automatic logic [15:0] alu(input logic [15:0] x, input logic [15:0] y,
                                        input logic [5:0] c);
        logic [15:0] o;
        if (c[5]) x = 16'h0;
        if (c[4]) x = ~x;
        if (c[3]) y = 16'h0;
        if (c[2]) y = ~y;
        o = c[1] ? x + y : x & y;
        return c[0] ? ~o : o;
    endfunction

    // Model: walks each instruction as a timeline of clock edges.
    logic [15:0] e_a = 0, e_d = 0, e_wdata = 0;
    logic [14:0] e_pc = 0;
    logic        e_load = 0, e_halted = 0;
    logic [31:0] e_ret = 0;
    logic        m_on = 0, chk_on = 0;

    initial begin : model
        logic [15:0] ir, mdr, out;
        logic        jmp;
        ir = 0; mdr = 0;
        wait (m_on);
        forever begin
            forever begin
                @(posedge clk);
                if (halt) e_halted = 1'b1;
                else begin
                    e_halted = 1'b0;
                    if (instr_valid) begin
                        ir  = rom[e_pc];
                        mdr = mram[e_a];
                        break;
                    end
                end
            end
            @(posedge clk);
            if (!ir[15]) begin
                e_a   = ir;
                e_pc  = e_pc + 15'd1;
                e_ret = e_ret + 32'd1;
            end else begin
                out     = alu(e_d, ir[12] ? mdr : e_a, ir[11:6]);
                e_load  = ir[3];
                e_wdata = out;
                do @(posedge clk); while (ir[3] && slow(e_a) && mem_busy);
                jmp = (ir[2] && out[15]) || (ir[1] && out == 16'h0) ||
                      (ir[0] && !out[15] && out != 16'h0);
                if (ir[3]) mram[e_a] = out;
                e_pc = jmp ? e_a[14:0] : e_pc + 15'd1;
                if (ir[5]) e_a = out;
                if (ir[4]) e_d = out;
                e_load = 1'b0;
                e_ret  = e_ret + 32'd1;
            end
            forever begin
                @(posedge clk);
                if (!slow(e_a)) break;
                if (!mem_busy) begin
                    repeat (2) @(posedge clk);
                    break;
                end
            end
        end
    end

    always @(negedge clk) if (chk_on) begin
        chk("pc", 32'(prog_counter), 32'(e_pc));
        chk("mem_address", 32'(mem_address), 32'(e_a));
        chk("mem_load", 32'(mem_load), 32'(e_load));
        chk("halted", 32'(halted), 32'(e_halted));
        if (e_load) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
`ifdef HACK_CPU_RETIRE_CNT_EN
        chk("retired", retired, e_ret);
`endif
    end

    task automatic wait_pc(input logic [14:0] target, input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (prog_counter == target) break;
        end
        chk(nm, 32'(prog_counter), 32'(target));
    endtask

    initial begin
        reset_n = 1'b0; instr_valid = 1'b0; halt = 1'b0; mem_busy = 1'b0;
        for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;
        for (int i = 0; i < 65536; i++) begin
            ram[i]  = 16'(i) ^ 16'h5A5A;
            mram[i] = 16'(i) ^ 16'h5A5A;
        end
        rom[0]  = 16'h0010; rom[1]  = 16'h4000; rom[2]  = 16'hEDD0; rom[3]  = 16'hE308;
        rom[4]  = 16'hEA90; rom[5]  = 16'h0020; rom[6]  = 16'hE302;
        rom[32] = 16'hEFD0; rom[33] = 16'hE302; rom[34] = 16'hEE90; rom[35] = 16'hE308;
        rom[36] = 16'h7FFF; rom[37] = 16'hEA87; rom[32767] = 16'h0030;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_load", 32'(mem_load), 32'd0);
        chk("rst_pc", 32'(prog_counter), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);

        @(posedge clk); #1;
        reset_n = 1'b1; instr_valid = 1'b1; m_on = 1'b1; chk_on = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("a_instr_addr", 32'(mem_address), 32'h0010);
        chk("a_instr_pc", 32'(prog_counter), 32'd1);

        // M=D at A=0x4000 enters EXEC 16 cycles after reset; hold busy for 5 of its cycles.
        repeat (13) @(posedge clk); #1 mem_busy = 1'b1;
        repeat (5) @(posedge clk);  #1 mem_busy = 1'b0;
        @(negedge clk);
        chk("stall_load", 32'(mem_load), 32'd1);
        chk("stall_wdata", 32'(mem_wdata), 32'h4001);
        @(negedge clk);
        chk("after_commit_load", 32'(mem_load), 32'd0);
        repeat (3) @(negedge clk);
        chk("slow_done_pc", 32'(prog_counter), 32'd4);
        chk("slow_write", 32'(ram[16'h4000]), 32'h4001);

        wait_pc(15'h0020, 40, "jeq_taken");
        wait_pc(15'h0022, 20, "jeq_not_taken");
        wait_pc(15'h7FFF, 40, "jmp_to_top");
        chk("d_minus_one", 32'(ram[16'h0020]), 32'hFFFF);
        wait_pc(15'h0000, 10, "pc_wrap");
        chk("wrap_addr", 32'(mem_address), 32'h0030);

        wait_pc(15'h0002, 20, "pre_halt_pc");
        repeat (4) @(posedge clk); #1 halt = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (halted) break;
        end
        chk("halt_seen", 32'(halted), 32'd1);
        chk("halt_completed_pc", 32'(prog_counter), 32'd3);
        repeat (3) @(negedge clk);
        chk("halt_parked_pc", 32'(prog_counter), 32'd3);

        for (int i = 0; i < 32768; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 2))
                    0:       rom[i] = 16'h4000 + 16'($urandom_range(0, 31));
                    1:       rom[i] = 16'($urandom_range(0, 63));
                    default: rom[i] = 16'($urandom_range(0, 32767));
                endcase
            end else rom[i] = {3'b111, 13'($urandom)};
        end

        @(posedge clk); #1 halt = 1'b0; instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("unhalt_halted", 32'(halted), 32'd0);
        chk("no_valid_pc", 32'(prog_counter), 32'd3);

        repeat (3000) begin
            @(posedge clk); #1;
            instr_valid = ($urandom_range(0, 3) != 0);
            halt        = ($urandom_range(0, 15) == 0);
            mem_busy    = ($urandom_range(0, 3) == 0);
        end

        @(posedge clk); #1 halt = 1'b1; mem_busy = 1'b0; instr_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (halted) break;
        end
        chk("final_halt", 32'(halted), 32'd1);
        rom[prog_counter] = 16'hE308;
        @(posedge clk); #1 halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_load) break;
        end
        chk("exec_store_seen", 32'(mem_load), 32'd1);
        chk_on  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_load", 32'(mem_load), 32'd0);
        chk("async_pc", 32'(prog_counter), 32'd0);
        chk("async_addr", 32'(mem_address), 32'd0);
        chk("async_halted", 32'(halted), 32'd0);
`ifdef HACK_CPU_RETIRE_CNT_EN
        chk("async_retired", retired, 32'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end
endmodule
